// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative multiply/divide unit with HI/LO result registers.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      synchronous active-low reset
//   start        request, sampled only while idle
//   op           000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   src_a        multiplicand / dividend / MTHI-MTLO data
//   src_b        multiplier / divisor
//   busy         high while a mul/div is in flight
//   done         one-cycle pulse after HI/LO receive a mul/div result
//   div_by_zero  valid with done; DIV/DIVU with src_b == 0
//   hi, lo       HI and LO registers
//   dbg_state    current FSM state
//
// Handshake: a request is taken when start is high at a rising edge with busy
// low; there is no queueing, so start while busy is dropped. done is asserted
// for exactly one cycle with busy already low, so a new start may be presented
// in that same cycle.
module muldiv_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_next;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;    // partial product high half / partial remainder
  logic [WIDTH-1:0] qr;     // multiplier being consumed / dividend becoming quotient
  logic [WIDTH-1:0] bv;     // multiplicand or divisor magnitude
  logic             neg_q;  // product or quotient must be negated
  logic             neg_r;  // remainder takes the dividend's sign
  logic             dbz;
  logic             is_div;

  // Operand magnitudes for the signed ops (op[0] == 0 means signed).
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = ~op[0] & src_a[WIDTH-1];
    b_neg = ~op[0] & src_b[WIDTH-1];
    a_mag = a_neg ? -src_a : src_a;
    b_mag = b_neg ? -src_b : src_b;
  end

  // STEP shift-add steps, multiplier bits consumed LSB first.
  logic [WIDTH:0]   mt;
  logic [WIDTH-1:0] m_acc, m_q;

  always_comb begin
    mt    = '0;
    m_acc = acc;
    m_q   = qr;
    for (int i = 0; i < STEP; i++) begin
      mt = {1'b0, m_acc};
      if (m_q[0]) mt = mt + {1'b0, bv};
      m_q   = {mt[0], m_q[WIDTH-1:1]};
      m_acc = mt[WIDTH:1];
    end
  end

  // STEP restoring-division steps, quotient bits resolved MSB first.
  // The remainder stays below the divisor, so WIDTH+1 bits never overflow.
  logic [WIDTH:0]   du;
  logic [WIDTH-1:0] d_r, d_q;

  always_comb begin
    du  = '0;
    d_r = acc;
    d_q = qr;
    for (int i = 0; i < STEP; i++) begin
      du  = {d_r, d_q[WIDTH-1]};
      d_q = {d_q[WIDTH-2:0], 1'b0};
      if (du >= {1'b0, bv}) begin
        du     = du - {1'b0, bv};
        d_q[0] = 1'b1;
      end
      d_r = du[WIDTH-1:0];
    end
  end

  // Sign correction. Divide by zero forces the quotient to all ones; the
  // remainder then holds |src_a| and the dividend-sign fix restores src_a.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    prod   = neg_q ? -{acc, qr} : {acc, qr};
    quo    = dbz ? '1 : (neg_q ? -qr : qr);
    rem    = neg_r ? -acc : acc;
    fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? quo : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !op[2]) state_next = op[1] ? DIV : MUL;
      MUL:     if (cnt == '0) state_next = FIX;
      DIV:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      acc         <= '0;
      qr          <= '0;
      bv          <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      is_div      <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              acc    <= '0;
              qr     <= op[1] ? a_mag : b_mag;
              bv     <= op[1] ? b_mag : a_mag;
              cnt    <= CW'(N);
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              dbz    <= op[1] && (src_b == '0);
              is_div <= op[1];
            end else if (op == 3'b100) begin
              hi <= src_a;
            end else if (op == 3'b101) begin
              lo <= src_a;
            end
          end
        end
        MUL: begin
          if (cnt != '0) begin
            acc <= m_acc;
            qr  <= m_q;
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (cnt != '0) begin
            acc <= d_r;
            qr  <= d_q;
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          hi          <= fix_hi;
          lo          <= fix_lo;
          done        <= 1'b1;
          div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Testbench for muldiv_hilo_unit (WIDTH=32, STEP=1): directed vectors with
// hand-computed results; a monitor pops expected results on every done pulse.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  muldiv_hilo_unit #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_hi", hi, e.hi);
        check("done_lo", lo, e.lo);
        check("done_dbz", div_by_zero, e.dbz);
        check("done_cycle", cyc, e.cyc);
        check("done_busy_low", busy, 1'b0);
      end
    end
  end

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input bit inject);
    exp_t e;
    int   bc;
    bit   seen;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    e.cyc = cyc + 34;
    exp_q.push_back(e);
    bc   = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
      end else begin
        if (busy) bc++;
        if (inject && i == 5) begin
          op    = 3'b100;
          src_a = 32'h1234_5678;
          start = 1'b1;
        end
        if (i == 6) start = 1'b0;
        if (i == 20) begin
          check("hold_hi", hi, model_hi);
          check("hold_lo", lo, model_lo);
        end
      end
    end
    check("done_seen", seen, 1'b1);
    check("busy_cycles", bc, 34);
    model_hi = ehi;
    model_lo = elo;
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'b000;
    src_a   = '0;
    src_b   = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);

    // mul/div vectors, issued back-to-back in each done cycle
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(3'b011, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(3'b010, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 0);
    run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
    run_op(3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0);
    // MTHI while busy must be dropped
    run_op(3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);

    // MTHI / MTLO in idle
    op = 3'b100; src_a = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", busy, 1'b0);
    check("mthi_done", done, 1'b0);
    model_hi = 32'h1234_5678;
    op = 3'b101; src_a = 32'hAABB_CCDD; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'hAABB_CCDD);
    check("mtlo_hi_kept", hi, model_hi);
    model_lo = 32'hAABB_CCDD;

    // reserved op: no effect
    op = 3'b110; src_a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("nop_busy", busy, 1'b0);
    check("nop_hi", hi, model_hi);
    check("nop_lo", lo, model_lo);

    // reset wins over start on the same edge
    reset_n = 1'b0; op = 3'b000; src_a = 32'h3; src_b = 32'h5; start = 1'b1;
    @(posedge clk); #1 begin reset_n = 1'b1; start = 1'b0; end
    @(negedge clk);
    check("rstprio_busy", busy, 1'b0);
    check("rstprio_hi", hi, 32'h0);
    check("rstprio_lo", lo, 32'h0);
    model_hi = '0;
    model_lo = '0;

    // reset in cycle 10 of a DIV discards the result
    run_op(3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 0);
    op = 3'b010; src_a = 32'h0000_1000; src_b = 32'h0000_0003; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_done", done, 1'b0);
    model_hi = '0;
    model_lo = '0;
    // start in the following cycle is accepted
    run_op(3'b011, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand, HI and LO width; even, at least 4.
REQ-002 SHALL have parameter STEP, default 1: quotient/product bits resolved per iteration cycle; must divide WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
REQ-007 SHALL have port src_a  input  WIDTH  multiplicand/dividend, or MTHI/MTLO data.
REQ-008 SHALL have port src_b  input  WIDTH  multiplier/divisor.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; the CPU stalls on it.
REQ-010 SHALL have port done  output  1  one-cycle pulse when HI/LO receive a mul/div result.
REQ-011 SHALL have port div_by_zero  output  1  valid with done; set for DIV/DIVU with src_b==0.
REQ-012 SHALL have port hi  output  WIDTH  HI register.
REQ-013 SHALL have port lo  output  WIDTH  LO register.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX; busy = (state != IDLE).
REQ-015 IDLE with start and op MULT/MULTU/DIV/DIVU SHALL latch operands as magnitudes (signed ops) plus result-sign bits, load iteration counter N = WIDTH/STEP, and enter MUL or DIV.
REQ-016 MUL SHALL perform shift-add, STEP multiplier bits per cycle; DIV SHALL perform restoring division, STEP quotient bits per cycle; after N cycles both enter FIX.
REQ-017 FIX SHALL apply two's-complement sign correction, write hi/lo, set done for the following cycle, and return to IDLE.
REQ-018 Latency: the start edge is edge 0; hi/lo change on edge N+2 and done is high during the cycle after it (34 edges for WIDTH=32, STEP=1).
REQ-019 Products SHALL be 2*WIDTH bits: hi = upper half, lo = lower half; MULT signed x signed, MULTU unsigned.
REQ-020 Division SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-021 Divide by zero SHALL keep the full latency and give lo = all ones, hi = src_a, div_by_zero = 1.
REQ-022 Signed DIV of the minimum value by -1 SHALL give lo = minimum value, hi = 0, div_by_zero = 0.
REQ-023 MTHI/MTLO in IDLE with start SHALL write src_a to hi/lo on the next edge, leave busy low, and not pulse done.
REQ-024 start in any non-IDLE state SHALL be ignored (no queueing); hi/lo SHALL hold their values until FIX writes them.
REQ-025 start with op 110/111 SHALL have no effect.
REQ-026 done, when it pulses, SHALL coincide with busy low, so back-to-back start is accepted in the done cycle.

Reset
REQ-027 reset_n low at an edge SHALL force IDLE and clear hi, lo, counter, busy, done and div_by_zero to 0, including mid-operation; the partial result SHALL be discarded.
REQ-028 reset_n SHALL take priority over start on the same edge.

Verification (WIDTH=32, STEP=1)
REQ-029 MULT src_a=FFFFFFFD, src_b=00000005 -> busy for 34 cycles, then done, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-030 MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-031 DIV FFFFFFF9 / 00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
REQ-032 DIVU 00000064 / 0 -> done after 34 cycles, lo=FFFFFFFF, hi=00000064, div_by_zero=1.
REQ-033 MTHI 12345678 issued while busy -> ignored and final hi equals the mul/div result; MTHI issued in IDLE -> hi=12345678 next cycle, no done pulse.
REQ-034 reset_n low at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, no done; a start in the following cycle is accepted.
